// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: interrupt source
// codes, fetch state encoding and the BRK opcode injected on interrupts.
package fetch_unit_pkg;

  localparam logic [1:0] INT_NONE  = 2'd0;
  localparam logic [1:0] INT_IRQ   = 2'd1;
  localparam logic [1:0] INT_NMI   = 2'd2;
  localparam logic [1:0] INT_RESET = 2'd3;

  localparam logic [7:0] BRK_OPCODE = 8'h00;

  typedef enum logic [1:0] {
    FT_T0,
    FT_T1,
    FT_EXEC
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_int_ctl.sv
// Interrupt controller for the fetch unit: NMI falling-edge capture, reset
// and NMI pending flags, and priority encoding of the BRK injection source.
// Optional macro IRQ_SYNC_EN puts a 2-flop synchronizer on irq_n/nmi_n.
module fetch_unit_int_ctl
  import fetch_unit_pkg::*;
#(
  parameter bit BOOT_INT = 1'b1
) (
  input  logic       clk_m2,
  input  logic       rst,
  input  logic       irq_n,
  input  logic       nmi_n,
  input  logic       i_flag,
  input  logic       take,
  output logic       inject,
  output logic [1:0] win_src
);

  logic irq_line;
  logic nmi_line;
  logic nmi_prev;
  logic nmi_edge;
  logic nmi_pend;
  logic rst_pend;

`ifdef IRQ_SYNC_EN
  logic irq_s1, irq_s2, nmi_s1, nmi_s2;

  // Two-stage synchronizer for the asynchronous interrupt lines, idle high
  always_ff @(posedge clk_m2) begin
    if (rst) begin
      irq_s1 <= 1'b1;
      irq_s2 <= 1'b1;
      nmi_s1 <= 1'b1;
      nmi_s2 <= 1'b1;
    end else begin
      irq_s1 <= irq_n;
      irq_s2 <= irq_s1;
      nmi_s1 <= nmi_n;
      nmi_s2 <= nmi_s1;
    end
  end

  assign irq_line = irq_s2;
  assign nmi_line = nmi_s2;
`else
  assign irq_line = irq_n;
  assign nmi_line = nmi_n;
`endif

  // NMI history sampled every cycle, independent of rdy, so stalls never hide an edge
  always_ff @(posedge clk_m2) begin
    if (rst) nmi_prev <= 1'b1;
    else     nmi_prev <= nmi_line;
  end

  assign nmi_edge = nmi_prev & ~nmi_line;

  // Fixed priority: pending reset, then pending NMI, then unmasked IRQ level
  always_comb begin
    win_src = INT_NONE;
    if (rst_pend)                   win_src = INT_RESET;
    else if (nmi_pend)              win_src = INT_NMI;
    else if (!irq_line && !i_flag)  win_src = INT_IRQ;
    inject = (win_src != INT_NONE);
  end

  // Pending flags; a new NMI edge wins over the clear so it is never lost
  always_ff @(posedge clk_m2) begin
    if (rst) begin
      nmi_pend <= 1'b0;
      rst_pend <= BOOT_INT;
    end else begin
      nmi_pend <= (nmi_pend & ~(take && win_src == INT_NMI)) | nmi_edge;
      if (take && win_src == INT_RESET) rst_pend <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the bus for the opcode (T0) and first
// operand (T1) reads, maintains the PC and injects BRK for interrupts.
// Optional macro IRQ_SYNC_EN (see fetch_unit_int_ctl) synchronizes irq_n/nmi_n.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter bit          BOOT_INT = 1'b1
) (
  input  logic        clk_m2,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  data_i,
  output logic [15:0] addr_o,
  output logic        addr_en,
  output logic        sync_o,
  input  logic        fetch_req,
  input  logic        single_byte,
  input  logic        pc_load,
  input  logic [15:0] pc_val,
  output logic [15:0] pc_o,
  output logic [7:0]  opcode_o,
  output logic [7:0]  operand_o,
  output logic        opcode_valid,
  output logic [1:0]  int_src,
  input  logic        irq_n,
  input  logic        nmi_n,
  input  logic        i_flag
);

  fetch_state_t state, state_next;
  logic [15:0]  pc;
  logic         inj_active;
  logic         fetch_seen;
  logic         pc_inc;
  logic         take;
  logic         inject;
  logic [1:0]   win_src;

  assign take = (state == FT_T0) && rdy;

  fetch_unit_int_ctl #(.BOOT_INT(BOOT_INT)) u_int_ctl (
    .clk_m2  (clk_m2),
    .rst     (rst),
    .irq_n   (irq_n),
    .nmi_n   (nmi_n),
    .i_flag  (i_flag),
    .take    (take),
    .inject  (inject),
    .win_src (win_src)
  );

  // State register, frozen while rdy is low
  always_ff @(posedge clk_m2) begin
    if (rst)      state <= FT_T0;
    else if (rdy) state <= state_next;
  end

  // Next state, bus ownership and PC increment decision
  always_comb begin
    state_next   = state;
    addr_en      = 1'b0;
    sync_o       = 1'b0;
    opcode_valid = 1'b0;
    pc_inc       = 1'b0;
    case (state)
      FT_T0: begin
        addr_en    = 1'b1;
        sync_o     = 1'b1;
        pc_inc     = ~inject;
        state_next = FT_T1;
      end
      FT_T1: begin
        addr_en      = 1'b1;
        opcode_valid = rdy;
        pc_inc       = ~single_byte & ~inj_active;
        state_next   = FT_EXEC;
      end
      FT_EXEC: begin
        if (fetch_req || fetch_seen) state_next = FT_T0;
      end
      default: state_next = FT_T0;
    endcase
  end

  // Opcode/operand capture, injection bookkeeping and PC update
  always_ff @(posedge clk_m2) begin
    if (rst) begin
      pc         <= PC_RESET;
      opcode_o   <= 8'h00;
      operand_o  <= 8'h00;
      int_src    <= INT_NONE;
      inj_active <= 1'b0;
      fetch_seen <= 1'b0;
    end else if (rdy) begin
      case (state)
        FT_T0: begin
          opcode_o   <= inject ? BRK_OPCODE : data_i;
          int_src    <= win_src;
          inj_active <= inject;
          fetch_seen <= 1'b0;
        end
        FT_T1: begin
          operand_o  <= data_i;
          fetch_seen <= fetch_req;
        end
        default: fetch_seen <= 1'b0;
      endcase
      if (pc_load)     pc <= pc_val;
      else if (pc_inc) pc <= pc + 16'd1;
    end
  end

  assign addr_o = pc;
  assign pc_o   = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: boot BRK, 2-byte and
// single-byte fetches, IRQ/NMI injection, rdy stall, PC wrap and pc_load.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk_m2 = 1'b0;
  logic        rst, rdy, fetch_req, single_byte, pc_load;
  logic        irq_n, nmi_n, i_flag;
  logic [15:0] pc_val;
  logic [7:0]  data_i;
  logic [15:0] addr_o, pc_o;
  logic        addr_en, sync_o, opcode_valid;
  logic [7:0]  opcode_o, operand_o;
  logic [1:0]  int_src;

  logic [7:0]  mem [0:65535];
  int          vector_count = 0;
  int          miss_count = 0;

  always #5 clk_m2 = ~clk_m2;

  assign data_i = mem[addr_o];

  fetch_unit dut (
    .clk_m2       (clk_m2),
    .rst          (rst),
    .rdy          (rdy),
    .data_i       (data_i),
    .addr_o       (addr_o),
    .addr_en      (addr_en),
    .sync_o       (sync_o),
    .fetch_req    (fetch_req),
    .single_byte  (single_byte),
    .pc_load      (pc_load),
    .pc_val       (pc_val),
    .pc_o         (pc_o),
    .opcode_o     (opcode_o),
    .operand_o    (operand_o),
    .opcode_valid (opcode_valid),
    .int_src      (int_src),
    .irq_n        (irq_n),
    .nmi_n        (nmi_n),
    .i_flag       (i_flag)
  );

  task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are examined on the falling edge
  task automatic apply_stimulus;
    @(posedge clk_m2);
    @(negedge clk_m2);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'h0000] = 8'hA9;
    mem[16'h0001] = 8'h4C;
    mem[16'h0200] = 8'hA9;
    mem[16'h0201] = 8'h42;
    mem[16'h0300] = 8'hE8;
    mem[16'h0301] = 8'hCA;
    mem[16'h0400] = 8'hAD;
    mem[16'h0401] = 8'h34;
    mem[16'hFFFF] = 8'hA9;

    rst = 1'b1; rdy = 1'b1; fetch_req = 1'b0; single_byte = 1'b0;
    pc_load = 1'b0; pc_val = 16'h0000; irq_n = 1'b1; nmi_n = 1'b1; i_flag = 1'b1;

    // Reset state
    @(negedge clk_m2);
    @(negedge clk_m2);
    check_output("rst_sync", sync_o, 1);
    check_output("rst_addr_en", addr_en, 1);
    check_output("rst_pc", pc_o, 16'h0000);
    check_output("rst_opvalid", opcode_valid, 0);
    check_output("rst_int_src", int_src, INT_NONE);
    check_output("rst_opcode", opcode_o, 8'h00);
    check_output("rst_operand", operand_o, 8'h00);

    // Boot BRK injection
    rst = 1'b0;
    apply_stimulus;
    check_output("boot_opcode", opcode_o, 8'h00);
    check_output("boot_int_src", int_src, INT_RESET);
    check_output("boot_pc", pc_o, 16'h0000);
    check_output("boot_t1_sync", sync_o, 0);
    check_output("boot_t1_addr_en", addr_en, 1);
    check_output("boot_opvalid", opcode_valid, 1);
    pc_load = 1'b1; pc_val = 16'h0200;
    apply_stimulus;
    check_output("vec_pc", pc_o, 16'h0200);
    check_output("exec_addr_en", addr_en, 0);
    check_output("exec_opvalid", opcode_valid, 0);
    pc_load = 1'b0; fetch_req = 1'b1;
    apply_stimulus;
    fetch_req = 1'b0;
    check_output("t0_sync", sync_o, 1);
    check_output("t0_addr", addr_o, 16'h0200);

    // LDA #$42, two-byte op, no more reset pending
    apply_stimulus;
    check_output("lda_opcode", opcode_o, 8'hA9);
    check_output("lda_int_src", int_src, INT_NONE);
    check_output("lda_pc_t1", pc_o, 16'h0201);
    check_output("lda_opvalid", opcode_valid, 1);
    apply_stimulus;
    check_output("lda_operand", operand_o, 8'h42);
    check_output("lda_pc", pc_o, 16'h0202);
    check_output("lda_opvalid_off", opcode_valid, 0);
    apply_stimulus;
    check_output("exec_hold", addr_en, 0);
    pc_load = 1'b1; pc_val = 16'h0300; fetch_req = 1'b1;
    apply_stimulus;
    pc_load = 1'b0; fetch_req = 1'b0;
    check_output("jmp_pc", pc_o, 16'h0300);

    // INX, single-byte op with fetch_req at T1
    apply_stimulus;
    check_output("inx_opcode", opcode_o, 8'hE8);
    check_output("inx_pc_t1", pc_o, 16'h0301);
    single_byte = 1'b1; fetch_req = 1'b1;
    apply_stimulus;
    single_byte = 1'b0; fetch_req = 1'b0;
    check_output("inx_operand", operand_o, 8'hCA);
    check_output("inx_pc", pc_o, 16'h0301);
    check_output("inx_exec", addr_en, 0);
    apply_stimulus;
    check_output("inx_back_t0", sync_o, 1);
    check_output("inx_addr", addr_o, 16'h0301);

    // IRQ masked by i_flag
    irq_n = 1'b0; i_flag = 1'b1;
    apply_stimulus;
    check_output("irqm_opcode", opcode_o, 8'hCA);
    check_output("irqm_int_src", int_src, INT_NONE);
    check_output("irqm_pc", pc_o, 16'h0302);
    single_byte = 1'b1; fetch_req = 1'b1;
    apply_stimulus;
    single_byte = 1'b0; fetch_req = 1'b0;
    apply_stimulus;
    // IRQ unmasked
    i_flag = 1'b0;
    apply_stimulus;
    check_output("irq_opcode", opcode_o, 8'h00);
    check_output("irq_int_src", int_src, INT_IRQ);
    check_output("irq_pc", pc_o, 16'h0302);
    fetch_req = 1'b1;
    apply_stimulus;
    check_output("irq_exec_pc", pc_o, 16'h0302);
    nmi_n = 1'b0;
    apply_stimulus;
    // NMI pending beats the still-asserted IRQ
    apply_stimulus;
    nmi_n = 1'b1;
    check_output("nmi_opcode", opcode_o, 8'h00);
    check_output("nmi_int_src", int_src, INT_NMI);
    check_output("nmi_pc", pc_o, 16'h0302);
    apply_stimulus;
    apply_stimulus;
    apply_stimulus;
    check_output("irq_after_nmi", int_src, INT_IRQ);
    irq_n = 1'b1; i_flag = 1'b1;
    pc_load = 1'b1; pc_val = 16'h0400;
    apply_stimulus;
    apply_stimulus;
    pc_load = 1'b0; fetch_req = 1'b0;
    check_output("stall_setup_pc", pc_o, 16'h0400);

    // rdy stall in T1 with an NMI edge arriving during the stall
    apply_stimulus;
    check_output("stall_opcode", opcode_o, 8'hAD);
    rdy = 1'b0; nmi_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus;
      check_output("stall_addr", addr_o, 16'h0401);
      check_output("stall_pc", pc_o, 16'h0401);
      check_output("stall_opvalid", opcode_valid, 0);
      check_output("stall_state", {sync_o, addr_en}, 2'b01);
    end
    rdy = 1'b1; fetch_req = 1'b1; nmi_n = 1'b1;
    #1;
    check_output("stall_release_opvalid", opcode_valid, 1);
    apply_stimulus;
    check_output("stall_operand", operand_o, 8'h34);
    check_output("stall_pc_after", pc_o, 16'h0402);
    apply_stimulus;
    apply_stimulus;
    check_output("stall_nmi_src", int_src, INT_NMI);
    check_output("stall_nmi_pc", pc_o, 16'h0402);

    // PC wrap on a two-byte op at $FFFF
    pc_load = 1'b1; pc_val = 16'hFFFF;
    apply_stimulus;
    pc_load = 1'b0;
    check_output("wrap_load", pc_o, 16'hFFFF);
    apply_stimulus;
    apply_stimulus;
    check_output("wrap_opcode", opcode_o, 8'hA9);
    check_output("wrap_addr_t1", addr_o, 16'h0000);
    apply_stimulus;
    check_output("wrap_operand", operand_o, 8'hA9);
    check_output("wrap_pc", pc_o, 16'h0001);
    apply_stimulus;
    apply_stimulus;
    check_output("jmp_opcode", opcode_o, 8'h4C);
    pc_load = 1'b1; pc_val = 16'h8000;
    apply_stimulus;
    pc_load = 1'b0; fetch_req = 1'b0;
    check_output("load_over_inc", pc_o, 16'h8000);

    // Reset in the middle of a fetch
    rst = 1'b1;
    apply_stimulus;
    check_output("midrst_pc", pc_o, 16'h0000);
    check_output("midrst_sync", sync_o, 1);
    check_output("midrst_opcode", opcode_o, 8'h00);
    check_output("midrst_int_src", int_src, INT_NONE);
    rst = 1'b0;
    apply_stimulus;
    check_output("midrst_boot_src", int_src, INT_RESET);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end. Owns the address bus during opcode and first-operand cycles and maintains the PC.
- Captures the opcode and first operand byte, and injects BRK (8'h00) when an interrupt or reset is pending.
- Hands the opcode to the decoder and the T-state sequencer, which return the single-byte indication and the next fetch request.

Parameters:
PC_RESET, 16'h0000, PC value after rst (irrelevant once reset vector is loaded via pc_load)
BOOT_INT, 1, 1 = first instruction after rst is a forced BRK with int_src=INT_RESET

Ports:
clk_m2  in  1  system clock (phi2)
rst  in  1  reset, synchronous, active-high
rdy  in  1  bus ready; low stalls all state (read cycles only)
data_i  in  8  memory read data
addr_o  out  16  address bus when fetch owns it
addr_en  out  1  fetch unit driving addr_o (states T0/T1)
sync_o  out  1  opcode fetch cycle marker (state T0)
fetch_req  in  1  sequencer reached last cycle; begin new fetch next cycle
single_byte  in  1  from decoder, valid in cycle after opcode_valid
pc_load  in  1  load PC from pc_val (jump/branch/vector)
pc_val  in  16  new PC
pc_o  out  16  current PC
opcode_o  out  8  latched opcode (or 8'h00 on injection)
operand_o  out  8  latched first operand byte
opcode_valid  out  1  one-cycle pulse, opcode_o valid
int_src  out  2  INT_NONE/INT_IRQ/INT_NMI/INT_RESET for injected BRK
irq_n, nmi_n  in  1  interrupt lines, active-low
i_flag  in  1  P.I from status register

Behaviour:
- Reset (rst=1): state=T0, PC=PC_RESET, opcode_o=0, operand_o=0, opcode_valid=0, int_src=INT_NONE, nmi_pend=0, rst_pend=BOOT_INT, sync_o=1, addr_en=1.
- States: T0 (opcode read), T1 (operand read), EXEC (sequencer owns bus).
- All transitions and register updates are gated by rdy=1; rdy=0 holds every register, outputs remain stable.

T0:
- addr_o=PC, sync_o=1, addr_en=1.
- On the clock edge: opcode_o<=data_i, unless an injection is pending, in which case opcode_o<=8'h00.
- PC increments only if no injection.
- Next state is T1.

T1:
- addr_o=PC, addr_en=1.
- operand_o<=data_i, opcode_valid pulses for this cycle only.
- PC increments iff !single_byte && !injecting.
- Next state is EXEC.

EXEC:
- addr_en=0. Stay until fetch_req=1, then go to T0 on the next cycle.
- If fetch_req is asserted in the same cycle as the T1 exit (2-cycle ops), EXEC lasts exactly 1 cycle.

Injection priority, sampled at T0: rst_pend > nmi_pend > (irq level low && !i_flag).
- int_src latches the winner, INT_NONE otherwise.
- The injected opcode is 8'h00 and PC is not incremented, so the return address is the interrupted instruction.
- rst_pend clears on injection. nmi_pend clears on injection as INT_NMI.

NMI:
- Falling-edge detect on nmi_n, sampled every cycle regardless of rdy.
- Sets nmi_pend. An edge arriving during an NMI injection cycle re-arms nmi_pend (not lost).
- IRQ is level-sensitive and not latched; deasserted before T0 = ignored.

PC:
- pc_load has priority over increment in any state.
- PC wraps 16'hFFFF -> 16'h0000.
- rst mid-fetch aborts to T0 with reset values.

Optional Feature:
IRQ_SYNC_EN:
- Defined: irq_n and nmi_n pass through a 2-flop synchronizer clocked by clk_m2 (reset to 1) before edge detection and priority logic. This adds 2 cycles of latency.
- Undefined: lines are used directly (assumed synchronous).

Decomposition:
- Shared package 6502_defs: INT_NONE=2'd0, INT_IRQ=2'd1, INT_NMI=2'd2, INT_RESET=2'd3; fetch state enum (FT_T0, FT_T1, FT_EXEC); BRK_OPCODE=8'h00.
- Sub-module int_ctl: NMI edge detect, optional synchronizer, pending flags, priority encode to int_src/inject.

Test Plan:
- Post-reset, BOOT_INT=1, data_i=8'hA9 -> opcode_o=8'h00, int_src=INT_RESET, PC stays 16'h0000 after T0; rst_pend cleared for next fetch.
- PC=16'h0200, mem[0200]=8'hA9 (LDA #), mem[0201]=8'h42, single_byte=0 -> opcode_o=A9, operand_o=42, opcode_valid one cycle, PC=16'h0202.
- PC=16'h0300, mem[0300]=8'hE8 (INX), single_byte=1, fetch_req at T1 -> operand read at 0301, PC=16'h0301, back to T0 after 1 EXEC cycle.
- irq_n=0, i_flag=1 at T0 -> normal fetch. i_flag=0 -> opcode_o=00, int_src=INT_IRQ, PC unchanged. nmi_n falling concurrently -> int_src=INT_NMI, IRQ serviced next fetch.
- rdy=0 for 3 cycles during T1 -> addr_o, PC, state frozen, no opcode_valid until rdy=1. nmi_n falling edge during stall still captured.
- PC=16'hFFFF fetch of 2-byte op -> operand at 16'h0000, PC=16'h0001. pc_load=1 with pc_val=16'h8000 in T1 -> PC=16'h8000 (no increment).
